circuit2_seq_ctrl: RTL and testbench

- Multi-cycle, resource-shared sequencer for the circuit_2 dataflow.
- Computes x, z and h from a, b, c using one shared add/sub unit, one comparator and one shifter pair, instead of a fully parallel datapath.
- An FSM steps the shared unit through the operations.
- Start/busy/done handshake; sits between a host controller and the result registers.

---
 rtl/circuit2_seq_ctrl.sv | 101 ++++++++++
 tb/tb_circuit2_seq_ctrl.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/circuit2_seq_ctrl.sv
// Resource-shared sequencer computing x, z, h from a, b, c with one add/sub unit.
// Latency: done 5 cycles after start is accepted; start ignored while busy (no queueing).
module circuit2_seq_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] x,
  output logic [WIDTH-1:0] z,
  output logic [WIDTH-1:0] h
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ADD_D = 3'd1,
    ADD_E = 3'd2,
    SUB_F = 3'd3,
    CMP   = 3'd4,
    WB    = 3'd5
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_r, b_r, c_r, d_r, e_r, f_r;
  logic             lt_r, eq_r;
  logic [WIDTH-1:0] alu_b, alu_res, g;

  // Shared add/sub: first operand is always a_r, second and op come from state.
  always_comb begin
    alu_b   = (state == ADD_E) ? c_r : b_r;
    alu_res = (state == SUB_F) ? (a_r - alu_b) : (a_r + alu_b);
    g       = lt_r ? e_r : d_r;
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      x     <= '0;
      z     <= '0;
      h     <= '0;
      a_r   <= '0;
      b_r   <= '0;
      c_r   <= '0;
      d_r   <= '0;
      e_r   <= '0;
      f_r   <= '0;
      lt_r  <= 1'b0;
      eq_r  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_r   <= a;
            b_r   <= b;
            c_r   <= c;
            busy  <= 1'b1;
            state <= ADD_D;
          end
        end
        ADD_D: begin
          d_r   <= alu_res;
          state <= ADD_E;
        end
        ADD_E: begin
          e_r   <= alu_res;
          state <= SUB_F;
        end
        SUB_F: begin
          f_r   <= alu_res;
          state <= CMP;
        end
        CMP: begin
          lt_r  <= (d_r < e_r);
          eq_r  <= (d_r == e_r);
          state <= WB;
        end
        WB: begin
          x     <= g << lt_r;
          z     <= g >> eq_r;
          h     <= eq_r ? f_r : g;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_circuit2_seq_ctrl.sv
// Directed bench for circuit2_seq_ctrl: vector table plus busy-ignore, mid-reset and back-to-back sequences.
module tb_circuit2_seq_ctrl;

  localparam int W = 32;

  logic         Clk = 1'b0;
  logic         Rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a = '0, b = '0, c = '0;
  logic         busy, done;
  logic [W-1:0] x, z, h;

  int n_checks = 0;
  int n_fail   = 0;

  circuit2_seq_ctrl #(.WIDTH(W)) dut (
    .Clk(Clk), .Rst(Rst), .start(start), .a(a), .b(b), .c(c),
    .busy(busy), .done(done), .x(x), .z(z), .h(h)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    string        name;
    logic [W-1:0] a, b, c;
    logic [W-1:0] x, z, h;
  } vec_t;

  vec_t vecs [4];

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic chk_result(input string nm, input vec_t v);
    chk({nm, " done"}, {31'd0, done}, 32'd1);
    chk({nm, " busy in done cycle"}, {31'd0, busy}, 32'd0);
    chk({nm, " x"}, x, v.x);
    chk({nm, " z"}, z, v.z);
    chk({nm, " h"}, h, v.h);
  endtask

  // Issue one start at a negedge and check the full 5-cycle busy window and result.
  task automatic run_op(input vec_t v);
    start = 1'b1; a = v.a; b = v.b; c = v.c;
    @(negedge Clk);
    start = 1'b0;
    a = ~v.a; b = ~v.b; c = ~v.c;
    for (int k = 1; k <= 5; k++) begin
      if (k > 1) @(negedge Clk);
      chk($sformatf("%s busy k=%0d", v.name, k), {31'd0, busy}, 32'd1);
      chk($sformatf("%s no done k=%0d", v.name, k), {31'd0, done}, 32'd0);
    end
    @(negedge Clk);
    chk_result(v.name, v);
    @(negedge Clk);
    chk({v.name, " done cleared"}, {31'd0, done}, 32'd0);
    chk({v.name, " x held"}, x, v.x);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{name: "case1", a: 32'd5, b: 32'd3, c: 32'd1, x: 32'd8, z: 32'd8, h: 32'd8};
    vecs[1] = '{name: "case2", a: 32'd1, b: 32'd2, c: 32'd4, x: 32'd10, z: 32'd5, h: 32'd5};
    vecs[2] = '{name: "case3", a: 32'd10, b: 32'd4, c: 32'd4, x: 32'd14, z: 32'd7, h: 32'd6};
    vecs[3] = '{name: "case4_wrap", a: 32'hFFFF_FFFF, b: 32'd2, c: 32'd0,
                x: 32'hFFFF_FFFE, z: 32'hFFFF_FFFF, h: 32'hFFFF_FFFF};

    // Reset state
    @(negedge Clk);
    @(negedge Clk);
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset done", {31'd0, done}, 32'd0);
    chk("reset x", x, 32'd0);
    chk("reset z", z, 32'd0);
    chk("reset h", h, 32'd0);
    Rst = 1'b0;
    @(negedge Clk);

    for (int i = 0; i < 4; i++) run_op(vecs[i]);

    // start pulsed during ADD_E with other operands must be ignored
    start = 1'b1; a = vecs[0].a; b = vecs[0].b; c = vecs[0].c;
    @(negedge Clk);
    start = 1'b0;
    @(negedge Clk);
    start = 1'b1; a = vecs[1].a; b = vecs[1].b; c = vecs[1].c;
    @(negedge Clk);
    start = 1'b0;
    chk("ignore busy in SUB_F", {31'd0, busy}, 32'd1);
    @(negedge Clk);
    @(negedge Clk);
    @(negedge Clk);
    chk_result("ignore", vecs[0]);
    @(negedge Clk);
    chk("ignore no restart", {31'd0, busy}, 32'd0);
    chk("ignore done cleared", {31'd0, done}, 32'd0);

    // Reset asserted while in SUB_F aborts the operation
    start = 1'b1; a = vecs[1].a; b = vecs[1].b; c = vecs[1].c;
    @(negedge Clk);
    start = 1'b0;
    @(negedge Clk);
    @(negedge Clk);
    chk("pre-reset x holds case1", x, vecs[0].x);
    Rst = 1'b1;
    #1;
    chk("midrst busy", {31'd0, busy}, 32'd0);
    chk("midrst done", {31'd0, done}, 32'd0);
    chk("midrst x", x, 32'd0);
    chk("midrst z", z, 32'd0);
    chk("midrst h", h, 32'd0);
    @(negedge Clk);
    Rst = 1'b0;
    for (int k = 0; k < 7; k++) begin
      @(negedge Clk);
      chk($sformatf("postrst no done k=%0d", k), {31'd0, done}, 32'd0);
      chk($sformatf("postrst idle k=%0d", k), {31'd0, busy}, 32'd0);
    end
    run_op(vecs[0]);

    // Back-to-back: start held high, case3 operands presented in the done cycle
    start = 1'b1; a = vecs[1].a; b = vecs[1].b; c = vecs[1].c;
    for (int k = 1; k <= 6; k++) @(negedge Clk);
    chk_result("b2b first", vecs[1]);
    a = vecs[2].a; b = vecs[2].b; c = vecs[2].c;
    for (int k = 1; k <= 5; k++) begin
      @(negedge Clk);
      chk($sformatf("b2b gap no done k=%0d", k), {31'd0, done}, 32'd0);
      chk($sformatf("b2b gap busy k=%0d", k), {31'd0, busy}, 32'd1);
    end
    @(negedge Clk);
    start = 1'b0;
    chk_result("b2b second", vecs[2]);
    @(negedge Clk);
    @(negedge Clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
